// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
//
// Bundles the read, write, scoreboard and status signals of the two-read /
// two-write register file. The register file connects through the slave
// modport. The decode/writeback logic (or a testbench) connects through the
// master modport.
//
// Parameters:
//   WIDTH      data width in bits
//   REG_WIDTH  register index width
//
// Signals (direction as seen from the register file, i.e. the slave side):
//   ready           out  high once the post-reset init sweep is complete
//   rsIn, rtIn      in   read addresses
//   rsOut, rtOut    out  read data (combinational)
//   rsBusy, rtBusy  out  scoreboard pending bit of rsIn / rtIn
//   we0/rd0In/d0Val in   write port 0 (ALU writeback)
//   we1/rd1In/d1Val in   write port 1 (load writeback, wins on collision)
//   issue/issueRd   in   marks issueRd as having a write in flight
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5
);
    logic                 ready;
    logic [REG_WIDTH-1:0] rsIn;
    logic [REG_WIDTH-1:0] rtIn;
    logic [WIDTH-1:0]     rsOut;
    logic [WIDTH-1:0]     rtOut;
    logic                 rsBusy;
    logic                 rtBusy;
    logic                 we0;
    logic [REG_WIDTH-1:0] rd0In;
    logic [WIDTH-1:0]     d0Val;
    logic                 we1;
    logic [REG_WIDTH-1:0] rd1In;
    logic [WIDTH-1:0]     d1Val;
    logic                 issue;
    logic [REG_WIDTH-1:0] issueRd;

    modport master (
        input  ready, rsOut, rtOut, rsBusy, rtBusy,
        output rsIn, rtIn, we0, rd0In, d0Val, we1, rd1In, d1Val, issue, issueRd
    );

    modport slave (
        output ready, rsOut, rtOut, rsBusy, rtBusy,
        input  rsIn, rtIn, we0, rd0In, d0Val, we1, rd1In, d1Val, issue, issueRd
    );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Two-read / two-write register file with a RAW-hazard scoreboard.
// Register 0 reads as zero. Writes to register 0 are dropped, and register 0
// is never marked busy. After reset the file sweeps once through all
// registers and loads REG[i] = i. During that sweep the writes, issues and
// reads are masked. When the sweep completes, ready goes high.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When this macro is defined, a read whose nonzero address matches a write
//   in the same cycle returns the data being written. Port 1 takes priority
//   over port 0. When it is undefined, a write becomes visible on the cycle
//   after it is written.
//
// Ports:
//   clock    in   single clock, all state changes on posedge
//   reset_n  in   asynchronous active-low reset (restarts the sweep)
//   bus      slave modport of regfile_mp_if (reads, writes, scoreboard, ready)
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int NUM_REGS  = 32,
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    regfile_mp_if.slave   bus
);

    typedef enum logic {INIT, RUN} state_t;

    state_t               state, stateNext;
    logic [REG_WIDTH-1:0] cnt, cntNext;
    logic [NUM_REGS-1:0]  pending, pendingNext;
    logic [WIDTH-1:0]     regs [NUM_REGS];

    // Control state: sweep FSM, sweep counter and scoreboard are reset.
    // The data array is not reset; the sweep initialises it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            cnt     <= '0;
            pending <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            pending <= pendingNext;
        end
    end

    // The counter stops at its last value instead of wrapping. The FSM
    // leaves INIT on the same edge that performs the final sweep write.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            INIT: begin
                if (cnt == REG_WIDTH'(NUM_REGS - 1)) begin
                    stateNext = RUN;
                end else begin
                    cntNext = cnt + REG_WIDTH'(1);
                end
            end
            RUN: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    // Scoreboard. The issue is applied after the write clears, so a
    // same-cycle issue (the new producer) leaves the bit set.
    always_comb begin
        pendingNext = pending;
        if (state == RUN) begin
            if (bus.we0)   pendingNext[bus.rd0In]   = 1'b0;
            if (bus.we1)   pendingNext[bus.rd1In]   = 1'b0;
            if (bus.issue) pendingNext[bus.issueRd] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    // Array writes. Port 1 is written last, so it wins when both ports
    // target the same register.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            regs[cnt] <= WIDTH'(cnt);
        end else begin
            if (bus.we0 && bus.rd0In != '0) regs[bus.rd0In] <= bus.d0Val;
            if (bus.we1 && bus.rd1In != '0) regs[bus.rd1In] <= bus.d1Val;
        end
    end

    // Read port rs.
    always_comb begin
        bus.rsOut = '0;
        if (state == RUN && bus.rsIn != '0) begin
            bus.rsOut = regs[bus.rsIn];
`ifdef REGFILE_BYPASS_EN
            if (bus.we0 && bus.rd0In == bus.rsIn) bus.rsOut = bus.d0Val;
            if (bus.we1 && bus.rd1In == bus.rsIn) bus.rsOut = bus.d1Val;
`endif
        end
    end

    // Read port rt.
    always_comb begin
        bus.rtOut = '0;
        if (state == RUN && bus.rtIn != '0) begin
            bus.rtOut = regs[bus.rtIn];
`ifdef REGFILE_BYPASS_EN
            if (bus.we0 && bus.rd0In == bus.rtIn) bus.rtOut = bus.d0Val;
            if (bus.we1 && bus.rd1In == bus.rtIn) bus.rtOut = bus.d1Val;
`endif
        end
    end

    // Busy bits are the registered scoreboard; there is no bypass here.
    assign bus.rsBusy = pending[bus.rsIn];
    assign bus.rtBusy = pending[bus.rtIn];
    assign bus.ready  = (state == RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//
// Self-checking bench for regfile_mp with the default parameters
// (32 x 32-bit). It covers the reset sweep, a table of directed one-cycle
// vectors, and hand-written sequences for same-cycle bypass and mid-run reset.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int NUM_REGS  = 32;
    localparam int WIDTH     = 32;
    localparam int REG_WIDTH = 5;

    logic clock;
    logic reset_n;

    regfile_mp_if #(.WIDTH(WIDTH), .REG_WIDTH(REG_WIDTH)) bus ();

    regfile_mp #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .REG_WIDTH(REG_WIDTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        issue;
        logic [4:0]  issueRd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] expRs;
        logic [31:0] expRt;
        logic        expRsBusy;
        logic        expRtBusy;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int total;
    int passed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic clearInputs();
        bus.we0     = 1'b0;
        bus.rd0In   = '0;
        bus.d0Val   = '0;
        bus.we1     = 1'b0;
        bus.rd1In   = '0;
        bus.d1Val   = '0;
        bus.issue   = 1'b0;
        bus.issueRd = '0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Count the edges until ready goes high. The count is bounded, so a
    // stuck DUT still reaches the summary.
    task automatic waitReady(output int edges);
        edges = 0;
        while (bus.ready !== 1'b1 && edges < 100) begin
            tick();
            edges++;
            if (edges == 10) begin
                #1;
                check("init rsOut masked", bus.rsOut, 32'h0);
                check("init rtBusy masked", {31'b0, bus.rtBusy}, 32'h0);
                #1;
            end
        end
    endtask

    logic [31:0] expBypass;
    int          edges;

    initial begin
        total  = 0;
        passed = 0;

        // Vector table: {we0, rd0, d0, we1, rd1, d1, issue, issueRd, rs, rt,
        //                expRs, expRt, expRsBusy, expRtBusy}
        // The expected values are the outputs seen during the cycle, before
        // the edge. No entry reads a register that is written in the same
        // cycle, so the table holds with or without bypass.
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd7,  5'd31, 32'd7,      32'd31,     1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd1,  5'd2,  32'd1,      32'd2,      1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd6,  32'd0,      32'd6,      1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd5,  5'd0,  32'h1234,   32'd0,      1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd9,  32'hAAAA,     1'b1, 5'd9,  32'hBBBB, 1'b0, 5'd0,  5'd3,  5'd4,  32'd3,      32'd4,      1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd3,  32'h3333,     1'b1, 5'd4,  32'h4444, 1'b0, 5'd0,  5'd9,  5'd10, 32'hBBBB,   32'd10,     1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 5'd3,  5'd4,  32'h3333,   32'h4444,   1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd12, 5'd13, 32'd12,     32'd13,     1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd12, 5'd11, 5'd0,  32'd11,     32'd0,      1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd12, 5'd12, 32'hC0C0,   32'hC0C0,   1'b1, 1'b1};
        vecs[10] = '{1'b1, 5'd12, 32'h1212,     1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd14, 5'd15, 32'd14,     32'd15,     1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  5'd12, 5'd1,  32'h1212,   32'd1,      1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd12, 32'd0,      32'h1212,   1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd20, 5'd1,  5'd2,  32'd1,      32'd2,      1'b0, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd20, 5'd20, 5'd0,  32'd20,     32'd0,      1'b1, 1'b0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd20, 5'd20, 32'd20,     32'd20,     1'b1, 1'b1};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  5'd0,  5'd20, 32'd0,      32'd20,     1'b0, 1'b1};
        vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd16, 32'd0,      32'd16,     1'b0, 1'b0};

        // ---------------- reset and sweep ----------------
        clearInputs();
        bus.rsIn = 5'd7;
        bus.rtIn = 5'd12;
        reset_n  = 1'b1;
        #1;
        reset_n  = 1'b0;
        #1;
        check("reset ready", {31'b0, bus.ready}, 32'h0);
        check("reset rsOut", bus.rsOut, 32'h0);
        check("reset rsBusy", {31'b0, bus.rsBusy}, 32'h0);
        repeat (3) tick();
        // Drive writes and an issue during the sweep. The DUT must ignore them.
        bus.we0     = 1'b1;
        bus.rd0In   = 5'd7;
        bus.d0Val   = 32'h0BAD;
        bus.issue   = 1'b1;
        bus.issueRd = 5'd12;
        reset_n     = 1'b1;
        waitReady(edges);
        check("sweep edges to ready", edges, 32'd32);
        clearInputs();
        #1;
        check("sweep reg7", bus.rsOut, 32'd7);
        check("init issue ignored", {31'b0, bus.rtBusy}, 32'h0);
        check("sweep reg12", bus.rtOut, 32'd12);
        bus.rtIn = 5'd31;
        #1;
        check("sweep reg31", bus.rtOut, 32'd31);
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            bus.we0     = vecs[i].we0;
            bus.rd0In   = vecs[i].rd0;
            bus.d0Val   = vecs[i].d0;
            bus.we1     = vecs[i].we1;
            bus.rd1In   = vecs[i].rd1;
            bus.d1Val   = vecs[i].d1;
            bus.issue   = vecs[i].issue;
            bus.issueRd = vecs[i].issueRd;
            bus.rsIn    = vecs[i].rs;
            bus.rtIn    = vecs[i].rt;
            #1;
            check($sformatf("vec%0d rsOut", i), bus.rsOut, vecs[i].expRs);
            check($sformatf("vec%0d rtOut", i), bus.rtOut, vecs[i].expRt);
            check($sformatf("vec%0d rsBusy", i), {31'b0, bus.rsBusy}, {31'b0, vecs[i].expRsBusy});
            check($sformatf("vec%0d rtBusy", i), {31'b0, bus.rtBusy}, {31'b0, vecs[i].expRtBusy});
            tick();
        end
        clearInputs();

        // ---------------- same-cycle read of a written register ----------------
        bus.rsIn  = 5'd6;
        bus.rtIn  = 5'd7;
        bus.we0   = 1'b1;
        bus.rd0In = 5'd6;
        bus.d0Val = 32'h55;
`ifdef REGFILE_BYPASS_EN
        expBypass = 32'h55;
`else
        expBypass = 32'd6;
`endif
        #1;
        check("bypass same-cycle rs6", bus.rsOut, expBypass);
        tick();
        clearInputs();
        #1;
        check("bypass next-cycle rs6", bus.rsOut, 32'h55);

        // Both ports write register 7 while rt reads it: port 1 has priority.
        bus.we0   = 1'b1;
        bus.rd0In = 5'd7;
        bus.d0Val = 32'h70;
        bus.we1   = 1'b1;
        bus.rd1In = 5'd7;
        bus.d1Val = 32'h71;
`ifdef REGFILE_BYPASS_EN
        expBypass = 32'h71;
`else
        expBypass = 32'd7;
`endif
        #1;
        check("bypass priority rt7", bus.rtOut, expBypass);
        tick();
        clearInputs();
        #1;
        check("collision next-cycle rt7", bus.rtOut, 32'h71);
        tick();

        // ---------------- mid-operation reset ----------------
        bus.we0   = 1'b1;
        bus.rd0In = 5'd3;
        bus.d0Val = 32'hFFFF;
        tick();
        clearInputs();
        bus.issue   = 1'b1;
        bus.issueRd = 5'd8;
        tick();
        clearInputs();
        bus.rsIn = 5'd8;
        bus.rtIn = 5'd3;
        #1;
        check("pre-reset busy8", {31'b0, bus.rsBusy}, 32'h1);
        check("pre-reset reg3", bus.rtOut, 32'hFFFF);
        reset_n = 1'b0;
        #1;
        check("mid reset ready", {31'b0, bus.ready}, 32'h0);
        check("mid reset busy8", {31'b0, bus.rsBusy}, 32'h0);
        check("mid reset rtOut", bus.rtOut, 32'h0);
        tick();
        reset_n = 1'b1;
        waitReady(edges);
        check("resweep edges to ready", edges, 32'd32);
        #1;
        check("resweep reg3", bus.rtOut, 32'd3);
        check("resweep reg8", bus.rsOut, 32'd8);
        check("resweep busy8", {31'b0, bus.rsBusy}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised two-read / two-write register file for the pipelined datapath, replacing the single-write-port register file in the decode/writeback stages. Register 0 is hardwired to zero. After reset, a sequential sweep loads every register with its own index. A per-register scoreboard tracks writes that are in flight so decode can detect RAW hazards. Write port 0 carries ALU writeback; write port 1 carries the late load/memory result.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers (power of two, ≥ 4)
- WIDTH, 32, data width in bits
- REG_WIDTH, 5, register index width; must equal log2(NUM_REGS)

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- ready  out  1  high once the init sweep is complete
- rsIn, rtIn  in  REG_WIDTH  read addresses
- rsOut, rtOut  out  WIDTH  read data (combinational from array/bypass)
- rsBusy, rtBusy  out  1  scoreboard pending bit of rsIn / rtIn
- we0, rd0In, d0Val  in  1 / REG_WIDTH / WIDTH  write port 0 (ALU writeback)
- we1, rd1In, d1Val  in  1 / REG_WIDTH / WIDTH  write port 1 (load writeback)
- issue, issueRd  in  1 / REG_WIDTH  marks issueRd as pending a write

## Operation
- States are INIT and RUN.
- reset_n low: asynchronously enter INIT.
  - Sweep counter is set to 0.
  - ready=0.
  - All scoreboard bits are cleared.
  - Array contents are undefined until the sweep rewrites them.
- INIT: each cycle, write REG[cnt]=cnt (zero-extended to WIDTH), then increment cnt.
  - After the cnt=NUM_REGS-1 write, go to RUN.
  - In INIT, we0/we1/issue are ignored.
  - In INIT, rsOut/rtOut read 0 and rsBusy/rtBusy read 0.
- RUN: ready=1.
  - we0 writes d0Val to REG[rd0In]; we1 writes d1Val to REG[rd1In].
  - Both writes update on the same posedge.
  - Same rd on both ports in the same cycle: port 1 wins.
- Register 0:
  - Writes to register 0 are discarded.
  - Reads of register 0 return 0.
  - busy for register 0 is always 0, and issue to register 0 is ignored.
- Scoreboard (RUN only):
  - issue sets pending[issueRd].
  - An accepted write on either port clears pending[rd].
  - If issue and a write target the same register in the same cycle, the bit ends set (new producer wins).
  - Repeated issue to an already-pending register keeps it set.
- Read ports: rsOut/rtOut are the combinational array value (plus bypass when configured). rsBusy/rtBusy are the registered pending bits, with no bypass.

## Timing
- Reset values:
  - ready=0.
  - rsOut=rtOut=0.
  - rsBusy=rtBusy=0.
  - Sweep count=0.
- Init latency: NUM_REGS clock edges after reset_n deasserts.
  - ready rises after the edge that performs the last sweep write.
  - With defaults, ready is high after edge 32.
- Write latency: data is visible in the array after the posedge that samples we.
- Scoreboard latency: busy reflects issue/write one edge after sampling.
- Read latency: zero cycles; outputs follow addresses combinationally.
- reset_n asserted mid-sweep or mid-RUN: immediate return to INIT. The sweep restarts from 0 and all pending bits are lost.
- cnt is exactly REG_WIDTH bits. Terminal detection is cnt==NUM_REGS-1, with no wrap past it.

## Configuration
- REGFILE_BYPASS_EN defined, in RUN:
  - If rsIn (or rtIn) is nonzero and matches an active write's rd in the same cycle, the output is that write's data. Port 1 has priority over port 0.
  - Reading a register in the cycle it is written returns the new value.
- REGFILE_BYPASS_EN undefined: reads return the array value only. A same-cycle write is visible from the next cycle.
- Bypass never applies to register 0 or during INIT.

## Test plan
- Reset and sweep:
  - Stimulus: hold reset_n low for 3 cycles, then release, with NUM_REGS=32.
  - Required: ready=0 for 32 edges, then 1. Reading rs=7 returns 7, and reading rs=31 returns 31.
- Register 0 and a plain write:
  - Stimulus: we0=1, rd0In=0, d0Val=0xDEADBEEF, then read rs=0.
  - Required: rsOut=0.
  - Stimulus: write 0x1234 to register 5.
  - Required: rsOut=0x1234 on the next cycle.
- Dual-write collision:
  - Stimulus: we0=1 and we1=1, both rd=9, d0=0xAAAA, d1=0xBBBB.
  - Required: REG[9]=0xBBBB.
  - Stimulus: separate rds 3 and 4 written in the same cycle.
  - Required: both values land.
- Scoreboard:
  - Stimulus: issue rd=12.
  - Required: rsBusy=1 next cycle.
  - Stimulus: we1 to rd=12 in the same cycle as issue rd=12.
  - Required: busy stays 1.
  - Stimulus: a lone write to rd=12.
  - Required: busy=0 next cycle.
  - Stimulus: issue rd=0.
  - Required: busy stays 0.
- Bypass:
  - Stimulus: rsIn=6, with we0 writing 0x55 to rd=6 in the same cycle.
  - Required with REGFILE_BYPASS_EN: rsOut=0x55 in that cycle.
  - Required without it: rsOut keeps the old value (6), then 0x55 next cycle.
- Mid-operation reset:
  - Stimulus: after writing 0xFFFF to register 3 and issuing rd=8, pulse reset_n low for 1 cycle.
  - Required: ready drops immediately and busy for register 8 is 0. After 32 edges, REG[3]=3 again.
